// File: rtl/inert_intf_if.sv
// Bus between the inertial front end, its SPI monarch and the balance controller.
// The master modport is the front end's view of the bus.
interface inert_intf_if;
  logic        INT;
  logic        done;
  logic [15:0] rd_data;
  logic        wrt;
  logic [15:0] cmd;
  logic [15:0] ptch_rt;
  logic [15:0] ptch;
  logic        vld;

  modport master (
    input  INT, done, rd_data,
    output wrt, cmd, ptch_rt, ptch, vld
  );

  modport slave (
    output INT, done, rd_data,
    input  wrt, cmd, ptch_rt, ptch, vld
  );
endinterface

// File: rtl/inert_intf.sv
// Inertial sensor front end: configures the IMU over SPI, reads pitch rate and Z accel on
// each data-ready edge, and fuses them into a pitch estimate with a complementary filter.
module inert_intf #(
  parameter bit          fast_sim       = 1'b1,
  parameter logic [15:0] PTCH_RT_OFFSET = 16'h0050
) (
  input  logic         clk,
  input  logic         rst_n,
  inert_intf_if.master bus
);

  localparam logic [3:0] SETTLE = 4'd0;
  localparam logic [3:0] INIT0  = 4'd1;
  localparam logic [3:0] INIT1  = 4'd2;
  localparam logic [3:0] INIT2  = 4'd3;
  localparam logic [3:0] INIT3  = 4'd4;
  localparam logic [3:0] IDLE   = 4'd5;
  localparam logic [3:0] RD_RTL = 4'd6;
  localparam logic [3:0] RD_RTH = 4'd7;
  localparam logic [3:0] RD_AZL = 4'd8;
  localparam logic [3:0] RD_AZH = 4'd9;
  localparam logic [3:0] COMP   = 4'd10;
  localparam logic [3:0] VLD    = 4'd11;

  localparam logic [15:0]        SETTLE_MAX = fast_sim ? 16'h01FF : 16'hFFFF;
  localparam logic signed [26:0] FUSE_STEP  = 27'sd1024;

  logic [3:0]         state_q, state_d;
  logic [15:0]        settleCnt_q, settleCnt_d;
  logic               wrt_q, wrt_d;
  logic [15:0]        cmd_q, cmd_d;
  logic [2:0]         intSync_q;
  logic               intRise;
  logic [7:0]         rtL_q, rtH_q, azL_q, azH_q;
  logic [15:0]        ptchRt_q, ptch_q;
  logic signed [26:0] ptchInt_q, ptchInt_d;
  logic               vld_q;

  logic [15:0]        rtCorr;
  logic signed [15:0] azWord;
  logic signed [28:0] azProd;
  logic signed [15:0] ptchAcc;
  logic signed [26:0] fusion;

  // Two flops resynchronise INT; the third holds the previous sample for edge detection.
  assign intRise = intSync_q[1] & ~intSync_q[2];

  assign rtCorr  = {rtH_q, rtL_q} - PTCH_RT_OFFSET;
  assign azWord  = {azH_q, azL_q};
  assign azProd  = $signed({{13{azWord[15]}}, azWord}) * 29'sd327;
  assign ptchAcc = 16'(azProd >>> 13);
  assign fusion  = (ptchAcc > $signed(ptch_q)) ? FUSE_STEP : -FUSE_STEP;
  assign ptchInt_d = ptchInt_q - $signed({{11{rtCorr[15]}}, rtCorr}) + fusion;

  // Every transition into a SPI state launches its transaction on the same edge.
  always_comb begin
    state_d     = state_q;
    settleCnt_d = settleCnt_q;
    wrt_d       = 1'b0;
    cmd_d       = cmd_q;
    case (state_q)
      SETTLE: begin
        if (settleCnt_q == SETTLE_MAX) begin
          state_d = INIT0;
          wrt_d   = 1'b1;
          cmd_d   = 16'h0D02;
        end else begin
          settleCnt_d = settleCnt_q + 16'd1;
        end
      end
      INIT0: if (bus.done) begin state_d = INIT1; wrt_d = 1'b1; cmd_d = 16'h1160; end
      INIT1: if (bus.done) begin state_d = INIT2; wrt_d = 1'b1; cmd_d = 16'h1250; end
      INIT2: if (bus.done) begin state_d = INIT3; wrt_d = 1'b1; cmd_d = 16'h1460; end
      INIT3: if (bus.done) state_d = IDLE;
      IDLE:   if (intRise)  begin state_d = RD_RTL; wrt_d = 1'b1; cmd_d = 16'hA200; end
      RD_RTL: if (bus.done) begin state_d = RD_RTH; wrt_d = 1'b1; cmd_d = 16'hA300; end
      RD_RTH: if (bus.done) begin state_d = RD_AZL; wrt_d = 1'b1; cmd_d = 16'hAC00; end
      RD_AZL: if (bus.done) begin state_d = RD_AZH; wrt_d = 1'b1; cmd_d = 16'hAD00; end
      RD_AZH: if (bus.done) state_d = COMP;
      COMP:   state_d = VLD;
      VLD:    state_d = IDLE;
      default: state_d = SETTLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SETTLE;
      settleCnt_q <= 16'h0000;
      wrt_q       <= 1'b0;
      cmd_q       <= 16'h0000;
      intSync_q   <= 3'b000;
    end else begin
      state_q     <= state_d;
      settleCnt_q <= settleCnt_d;
      wrt_q       <= wrt_d;
      cmd_q       <= cmd_d;
      intSync_q   <= {intSync_q[1:0], bus.INT};
    end
  end

  // Byte capture happens on the done cycle of the matching read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rtL_q <= 8'h00;
      rtH_q <= 8'h00;
      azL_q <= 8'h00;
      azH_q <= 8'h00;
    end else if (bus.done) begin
      case (state_q)
        RD_RTL:  rtL_q <= bus.rd_data[7:0];
        RD_RTH:  rtH_q <= bus.rd_data[7:0];
        RD_AZL:  azL_q <= bus.rd_data[7:0];
        RD_AZH:  azH_q <= bus.rd_data[7:0];
        default: ;
      endcase
    end
  end

  // Results are registered leaving COMP so they are visible in the VLD cycle with the strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptchRt_q  <= 16'h0000;
      ptchInt_q <= 27'sd0;
      ptch_q    <= 16'h0000;
      vld_q     <= 1'b0;
    end else begin
      vld_q <= (state_q == COMP);
      if (state_q == COMP) begin
        ptchRt_q  <= rtCorr;
        ptchInt_q <= ptchInt_d;
        ptch_q    <= ptchInt_d[26:11];
      end
    end
  end

  assign bus.wrt     = wrt_q;
  assign bus.cmd     = cmd_q;
  assign bus.ptch_rt = ptchRt_q;
  assign bus.ptch    = ptch_q;
  assign bus.vld     = vld_q;

endmodule

// File: tb/tb_inert_intf.sv
// Self-checking bench for inert_intf: SPI monarch model plus a scoreboard of expected
// pitch results, checked on every vld strobe.
module tb_inert_intf;

  typedef struct packed {
    logic [15:0] ptch;
    logic [15:0] rt;
  } expT;

  logic clk;
  logic rst_n;
  inert_intf_if bus();

  inert_intf #(.fast_sim(1'b1), .PTCH_RT_OFFSET(16'h0050)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checkCount = 0;
  int passCount  = 0;
  int cycleCnt   = 0;

  logic [15:0] cmdQ[$];
  expT         sbQ[$];
  expT         popped;

  logic [15:0]        curRt, curAz, curCmd, lastCmd;
  logic signed [26:0] mPtchInt;
  logic [15:0]        mPtch;
  bit                 busy, chainPending, firstWrtPending;
  int                 countdown, doneCycle, azhDoneCycle, releaseCycle;
  int                 wrtCount, vldCount;

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp)
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    else
      passCount++;
  endtask

  function automatic logic [7:0] respByte(input logic [15:0] c);
    case (c[15:8])
      8'hA2:   respByte = curRt[7:0];
      8'hA3:   respByte = curRt[15:8];
      8'hAC:   respByte = curAz[7:0];
      8'hAD:   respByte = curAz[15:8];
      default: respByte = 8'h00;
    endcase
  endfunction

  // Reference filter: computes the expected outputs of one sample and queues them.
  task automatic modelSample(input logic [15:0] rt, input logic [15:0] az);
    logic signed [15:0] rtc, acc;
    logic signed [26:0] fus;
    int prod, sh;
    expT e;
    rtc  = rt - 16'h0050;
    prod = $signed(az) * 327;
    sh   = prod >>> 13;
    acc  = sh[15:0];
    fus  = (acc > $signed(mPtch)) ? 27'sd1024 : -27'sd1024;
    mPtchInt = mPtchInt - {{11{rtc[15]}}, rtc} + fus;
    mPtch    = mPtchInt[26:11];
    e.ptch = mPtch;
    e.rt   = rtc;
    sbQ.push_back(e);
  endtask

  task automatic pushInitCmds();
    cmdQ.push_back(16'h0D02);
    cmdQ.push_back(16'h1160);
    cmdQ.push_back(16'h1250);
    cmdQ.push_back(16'h1460);
  endtask

  task automatic pulseInt();
    @(posedge clk); #1;
    bus.INT = 1'b1;
    repeat (2) @(posedge clk);
    #1 bus.INT = 1'b0;
  endtask

  task automatic applyStimulus(input logic [15:0] rt, input logic [15:0] az);
    curRt = rt;
    curAz = az;
    cmdQ.push_back(16'hA200);
    cmdQ.push_back(16'hA300);
    cmdQ.push_back(16'hAC00);
    cmdQ.push_back(16'hAD00);
    modelSample(rt, az);
    pulseInt();
  endtask

  task automatic waitVld(input int target);
    for (int i = 0; i < 400 && vldCount < target; i++) @(posedge clk);
    checkOutput("vldCount", 32'(vldCount), 32'(target));
  endtask

  task automatic waitCmd(input logic [15:0] c);
    for (int i = 0; i < 400 && lastCmd != c; i++) @(posedge clk);
    checkOutput("reachedCmd", {16'h0, lastCmd}, {16'h0, c});
  endtask

  task automatic waitInitDone();
    for (int i = 0; i < 2000 && (cmdQ.size() != 0 || busy); i++) @(posedge clk);
    checkOutput("initDrained", 32'(cmdQ.size()), 32'd0);
    repeat (5) @(posedge clk);
  endtask

  task automatic checkResetOutputs(input string phase);
    checkOutput({phase, "Wrt"},    {31'h0, bus.wrt}, 32'd0);
    checkOutput({phase, "Cmd"},    {16'h0, bus.cmd}, 32'd0);
    checkOutput({phase, "Vld"},    {31'h0, bus.vld}, 32'd0);
    checkOutput({phase, "Ptch"},   {16'h0, bus.ptch}, 32'd0);
    checkOutput({phase, "PtchRt"}, {16'h0, bus.ptch_rt}, 32'd0);
  endtask

  task automatic releaseReset();
    @(negedge clk);
    rst_n = 1'b1;
    releaseCycle = cycleCnt;
    firstWrtPending = 1'b1;
  endtask

  // SPI monarch model and output monitor, both sampled on the falling edge.
  initial begin
    bus.done = 1'b0;
    bus.rd_data = 16'h0000;
    forever begin
      @(negedge clk);
      bus.done = 1'b0;
      if (!rst_n) begin
        busy = 1'b0;
        countdown = 0;
        chainPending = 1'b0;
      end else begin
        if (bus.wrt) begin
          wrtCount++;
          lastCmd = bus.cmd;
          checkOutput("wrtWhileBusy", {31'h0, busy}, 32'd0);
          if (firstWrtPending) begin
            checkOutput("settleWait",
                        {31'h0, ((cycleCnt - releaseCycle) >= 512 && (cycleCnt - releaseCycle) <= 513)}, 32'd1);
            firstWrtPending = 1'b0;
          end
          if (chainPending) checkOutput("wrtGap", 32'(cycleCnt - doneCycle), 32'd1);
          chainPending = 1'b0;
          checkOutput("cmdQueued", {31'h0, cmdQ.size() > 0}, 32'd1);
          if (cmdQ.size() > 0) checkOutput("cmd", {16'h0, bus.cmd}, {16'h0, cmdQ.pop_front()});
          curCmd = bus.cmd;
          busy = 1'b1;
          countdown = 3;
        end else if (busy) begin
          countdown--;
          if (countdown == 0) begin
            busy = 1'b0;
            bus.done = 1'b1;
            bus.rd_data = {8'hA5, respByte(curCmd)};
            doneCycle = cycleCnt;
            if (curCmd == 16'hAD00) azhDoneCycle = cycleCnt;
            chainPending = !(curCmd == 16'h1460 || curCmd == 16'hAD00);
          end
        end
        if (bus.vld) begin
          vldCount++;
          checkOutput("vldLatency", 32'(cycleCnt - azhDoneCycle), 32'd2);
          checkOutput("sbQueued", {31'h0, sbQ.size() > 0}, 32'd1);
          if (sbQ.size() > 0) begin
            popped = sbQ.pop_front();
            checkOutput("ptch",   {16'h0, bus.ptch},    {16'h0, popped.ptch});
            checkOutput("ptchRt", {16'h0, bus.ptch_rt}, {16'h0, popped.rt});
          end
        end
      end
    end
  end

  initial begin
    int w0, v0;
    logic signed [15:0] prevPtch;
    rst_n = 1'b0;
    bus.INT = 1'b0;
    curRt = 16'h0; curAz = 16'h0; curCmd = 16'h0; lastCmd = 16'h0;
    mPtchInt = 27'sd0; mPtch = 16'h0;
    busy = 1'b0; chainPending = 1'b0; firstWrtPending = 1'b0;
    countdown = 0; doneCycle = 0; azhDoneCycle = 0; releaseCycle = 0;
    wrtCount = 0; vldCount = 0;

    // Reset state, settle wait and configuration writes.
    repeat (3) @(posedge clk);
    #1 checkResetOutputs("reset");
    pushInitCmds();
    releaseReset();
    waitInitDone();
    w0 = wrtCount;
    repeat (60) @(posedge clk);
    checkOutput("idleNoWrt", 32'(wrtCount), 32'(w0));
    checkOutput("idleNoVld", 32'(vldCount), 32'd0);

    // Zero corrected rate and zero accel: first sample lands at ptch = -1.
    applyStimulus(16'h0050, 16'h0000);
    waitVld(1);

    // Constant rate of 0x1000 after bias removal for 8 samples.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(16'h1050, 16'h0000);
      waitVld(vldCount + 1);
    end
    checkOutput("rateRunVlds", 32'(vldCount), 32'd9);

    // An INT edge during a burst must be dropped.
    v0 = vldCount;
    w0 = wrtCount;
    lastCmd = 16'h0;
    applyStimulus(16'h1234, 16'h0100);
    waitCmd(16'hAC00);
    pulseInt();
    waitVld(v0 + 1);
    repeat (40) @(posedge clk);
    checkOutput("droppedIntVld", 32'(vldCount), 32'(v0 + 1));
    checkOutput("droppedIntWrt", 32'(wrtCount - w0), 32'd4);
    applyStimulus(16'h0060, 16'hFF00);
    waitVld(v0 + 2);

    // Reset while RD_RTH waits for done, then full re-initialisation.
    lastCmd = 16'h0;
    applyStimulus(16'h0050, 16'h0000);
    waitCmd(16'hA300);
    #1 rst_n = 1'b0;
    #1 checkResetOutputs("midReset");
    cmdQ.delete();
    sbQ.delete();
    mPtchInt = 27'sd0;
    mPtch = 16'h0;
    pushInitCmds();
    repeat (3) @(posedge clk);
    releaseReset();
    waitInitDone();

    // Large positive accel: fusion pulls ptch upward every sample.
    prevPtch = 16'sh0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(16'h0050, 16'h7FFF);
      waitVld(vldCount + 1);
      checkOutput("ptchRising", {31'h0, $signed(bus.ptch) >= prevPtch}, 32'd1);
      prevPtch = $signed(bus.ptch);
    end
    checkOutput("sbDrained", 32'(sbQ.size()), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
